emif_avmm_arbiter: RTL

- Two-master, one-slave Avalon-MM arbiter that shares the single DDR4 EMIF Avalon-MM port.
- Master 0 is the PCIe AVMM DMA data mover; master 1 is the on-chip user/traffic-generator port.
- Round-robin grant, write bursts locked for their full length, pipelined reads tracked in a return-owner FIFO so read data is steered back to the issuer.
- Sits in the core_clkout domain between the DMA/user masters and the EMIF user interface.

---
 rtl/emif_avmm_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/emif_avmm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : emif_avmm_arbiter
// Description : Two-master, one-slave Avalon-MM arbiter sharing the DDR4 EMIF
//               port. Round-robin grant, write bursts locked for their full
//               length, and pipelined reads steered back to their issuer
//               through a return-owner FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module emif_avmm_arbiter #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 512,
    parameter int BURST_W   = 7,
    parameter int MAX_OUTST = 16
) (
    input  logic                         core_clkout,
    input  logic                         perstn_perstn,
    input  logic                         emif_cal_done,
    // master 0 : PCIe AVMM DMA data mover
    input  logic [ADDR_W-1:0]            m0_address,
    input  logic                         m0_read,
    input  logic                         m0_write,
    input  logic [BURST_W-1:0]           m0_burstcount,
    input  logic [DATA_W-1:0]            m0_writedata,
    input  logic [DATA_W/8-1:0]          m0_byteenable,
    output logic                         m0_waitrequest,
    output logic [DATA_W-1:0]            m0_readdata,
    output logic                         m0_readdatavalid,
    // master 1 : user / traffic-generator port
    input  logic [ADDR_W-1:0]            m1_address,
    input  logic                         m1_read,
    input  logic                         m1_write,
    input  logic [BURST_W-1:0]           m1_burstcount,
    input  logic [DATA_W-1:0]            m1_writedata,
    input  logic [DATA_W/8-1:0]          m1_byteenable,
    output logic                         m1_waitrequest,
    output logic [DATA_W-1:0]            m1_readdata,
    output logic                         m1_readdatavalid,
    // slave : EMIF user interface
    output logic [ADDR_W-1:0]            s_address,
    output logic [BURST_W-1:0]           s_burstcount,
    output logic [DATA_W-1:0]            s_writedata,
    output logic [DATA_W/8-1:0]          s_byteenable,
    output logic                         s_read,
    output logic                         s_write,
    input  logic                         s_waitrequest,
    input  logic [DATA_W-1:0]            s_readdata,
    input  logic                         s_readdatavalid,
    // status
    output logic [$clog2(MAX_OUTST):0]   rd_outstanding,
    output logic                         err_unexpected_rdv
);

    localparam int c_PTR_W = $clog2(MAX_OUTST);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_WBURST = 2'd2
    } state_t;

    state_t               r_state, w_next_state;
    logic                 r_grant, w_next_grant;
    logic                 r_last, w_next_last;
    logic [BURST_W-1:0]   r_beats_left, w_next_beats;

    // return-owner FIFO: owner id and effective burst length of each read
    logic                 r_fifo_owner [MAX_OUTST];
    logic [BURST_W-1:0]   r_fifo_bc    [MAX_OUTST];
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [BURST_W-1:0]   r_head_cnt;
    logic                 r_err;

    logic                 w_req0, w_req1;
    logic                 w_g_read, w_g_write;
    logic [BURST_W-1:0]   w_g_bc, w_g_bc_eff;
    logic                 w_g_wait;
    logic                 w_push, w_pop;
    logic                 w_fifo_full, w_fifo_empty;
    logic                 w_head_owner;
    logic [BURST_W-1:0]   w_head_bc;
    logic                 w_rdv_ok;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Slave-side command mux always follows the registered grant; the
    // strobes below decide whether anything is actually presented.
    assign w_g_read     = r_grant ? m1_read       : m0_read;
    assign w_g_write    = r_grant ? m1_write      : m0_write;
    assign w_g_bc       = r_grant ? m1_burstcount : m0_burstcount;
    assign w_g_bc_eff   = (w_g_bc == '0) ? BURST_W'(1) : w_g_bc;
    assign s_address    = r_grant ? m1_address    : m0_address;
    assign s_burstcount = r_grant ? m1_burstcount : m0_burstcount;
    assign s_writedata  = r_grant ? m1_writedata  : m0_writedata;
    assign s_byteenable = r_grant ? m1_byteenable : m0_byteenable;

    assign w_fifo_full  = (r_count == c_CNT_W'(MAX_OUTST));
    assign w_fifo_empty = (r_count == '0);

    // The non-granted master (and both masters in IDLE) always sees a stall.
    assign m0_waitrequest = r_grant ? 1'b1 : w_g_wait;
    assign m1_waitrequest = r_grant ? w_g_wait : 1'b1;

    // Arbitration / command-phase next-state and slave strobes
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_last  = r_last;
        w_next_beats = r_beats_left;
        s_read       = 1'b0;
        s_write      = 1'b0;
        w_g_wait     = 1'b1;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (emif_cal_done && (w_req0 || w_req1)) begin
                    // on a tie the master that did not win last time goes
                    w_next_grant = (w_req0 && w_req1) ? ~r_last : w_req1;
                    w_next_last  = w_next_grant;
                    w_next_state = ST_OWN;
                end
            end
            ST_OWN: begin
                if (w_g_write) begin
                    // a simultaneous read is left stalled behind the write
                    s_write  = 1'b1;
                    w_g_wait = s_waitrequest;
                    if (!s_waitrequest) begin
                        if (w_g_bc_eff == BURST_W'(1)) begin
                            w_next_state = ST_IDLE;
                        end else begin
                            w_next_beats = w_g_bc_eff - BURST_W'(1);
                            w_next_state = ST_WBURST;
                        end
                    end
                end else if (w_g_read) begin
                    // with no room to record the owner, hold the read back
                    if (!w_fifo_full) begin
                        s_read   = 1'b1;
                        w_g_wait = s_waitrequest;
                        if (!s_waitrequest) begin
                            w_push       = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end
                end else begin
                    // master withdrew its request; re-arbitrate
                    w_next_state = ST_IDLE;
                end
            end
            ST_WBURST: begin
                s_write  = w_g_write;
                w_g_wait = s_waitrequest;
                if (w_g_write && !s_waitrequest) begin
                    w_next_beats = r_beats_left - BURST_W'(1);
                    if (r_beats_left == BURST_W'(1)) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Arbiter state register; pointer starts as "last granted M1"
    always_ff @(posedge core_clkout or negedge perstn_perstn) begin
        if (!perstn_perstn) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last       <= 1'b1;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last       <= w_next_last;
            r_beats_left <= w_next_beats;
        end
    end

    // Read return path: head entry of the FIFO owns the current beat
    assign w_head_owner     = r_fifo_owner[r_rd_ptr];
    assign w_head_bc        = r_fifo_bc[r_rd_ptr];
    assign w_rdv_ok         = s_readdatavalid & ~w_fifo_empty;
    assign w_pop            = w_rdv_ok && ((r_head_cnt + BURST_W'(1)) == w_head_bc);
    assign m0_readdatavalid = w_rdv_ok & ~w_head_owner;
    assign m1_readdatavalid = w_rdv_ok &  w_head_owner;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    // FIFO storage needs no reset: entries are only read while occupied
    always_ff @(posedge core_clkout) begin
        if (w_push) begin
            r_fifo_owner[r_wr_ptr] <= r_grant;
            r_fifo_bc[r_wr_ptr]    <= w_g_bc_eff;
        end
    end

    // FIFO pointers, occupancy, head beat counter and sticky error
    always_ff @(posedge core_clkout or negedge perstn_perstn) begin
        if (!perstn_perstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // beats already returned for the head entry
            if (w_pop) begin
                r_head_cnt <= '0;
            end else if (w_rdv_ok) begin
                r_head_cnt <= r_head_cnt + BURST_W'(1);
            end
            if (s_readdatavalid && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rd_outstanding     = r_count;
    assign err_unexpected_rdv = r_err;

endmodule
`default_nettype wire
